// File: rtl/demux4_stream_pkg.sv
// Shared definitions for the demux4_stream block: channel count, select
// and counter widths, the per-channel buffer state encoding and the helper
// that locates a channel's slice in the flattened output data bus.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Lowest bit of channel ch's payload inside a NUM_CH*width flat bus.
    function automatic int unsigned slice_lo(input int unsigned ch,
                                             input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/demux4_stream_if.sv
// Handshake bundle between one producer and four consumers of the
// demux4_stream block. The slave modport is the demultiplexer's view.
interface demux4_stream_if
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [WIDTH-1:0]          in_data_i;
    logic [SEL_W-1:0]          in_sel_i;
    logic [NUM_CH-1:0]         out_valid_o;
    logic [NUM_CH-1:0]         out_ready_i;
    logic [NUM_CH*WIDTH-1:0]   out_data_o;
    logic [NUM_CH*CNT_W-1:0]   cnt_o;

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_data_i,
        input  in_sel_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output cnt_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_data_i,
        output in_sel_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  cnt_o
    );

endinterface

// File: rtl/demux4_stream_slot.sv
// One-entry registered buffer for a single output channel.
//
// state      | meaning
// SLOT_EMPTY | no beat held, out valid low
// SLOT_FULL  | beat held in data_q, presented until the consumer takes it
//
// load_i is only raised by the top when the buffer can take a beat, so a
// load while full always coincides with a drain (pass-through refill).
module demux4_slot
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // State and payload registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: load fills (or refills), drain without load empties.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                    data_d  = data_i;
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    data_d = data_i;
                end else if (ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign full_o = (state_q == SLOT_FULL);
    assign data_o = data_q;

endmodule

// File: rtl/demux4_stream.sv
// Stream demultiplexer: routes each input beat to one of four channels by
// its select, each channel buffered by a demux4_slot. Holds the select
// decode, the combinational in_ready_o and the optional per-channel
// accepted-beat counters, built only when DEMUX4_STREAM_CNT_EN is defined
// (otherwise cnt_o is tied to zero).
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    demux4_stream_if.slave bus
);

    logic [NUM_CH-1:0]       full_w;
    logic [WIDTH-1:0]        data_w [NUM_CH];
    logic [NUM_CH-1:0]       sel_dec;
    logic [NUM_CH-1:0]       load_w;
    logic                    in_ready_w;
    logic [NUM_CH*WIDTH-1:0] out_data_w;

    // One-hot decode of the destination channel.
    always_comb begin
        sel_dec = '0;
        sel_dec[bus.in_sel_i] = 1'b1;
    end

    // Accept when the target slot is empty or being drained this cycle.
    always_comb begin
        in_ready_w = ~full_w[bus.in_sel_i] | bus.out_ready_i[bus.in_sel_i];
        load_w     = (bus.in_valid_i && in_ready_w) ? sel_dec : '0;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux4_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (load_w[k]),
            .data_i  (bus.in_data_i),
            .ready_i (bus.out_ready_i[k]),
            .full_o  (full_w[k]),
            .data_o  (data_w[k])
        );
    end

    // Pack the channel payloads into the flat output bus.
    always_comb begin
        out_data_w = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_data_w[slice_lo(k, WIDTH) +: WIDTH] = data_w[k];
        end
    end

    assign bus.in_ready_o  = in_ready_w;
    assign bus.out_valid_o = full_w;
    assign bus.out_data_o  = out_data_w;

`ifdef DEMUX4_STREAM_CNT_EN
    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [CNT_W-1:0]        cnt_d [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] cnt_flat;

    // Count accepted beats per channel; 8-bit wrap is intended.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (load_w[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Flatten counters onto cnt_o.
    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign bus.cnt_o = cnt_flat;
`else
    assign bus.cnt_o = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed scenarios followed by random traffic,
// all checked against a channel-level model (full flag, payload, count).
module tb_demux4_stream;

    localparam int W = 8;

    logic clk;
    logic rst;

    demux4_stream_if #(.WIDTH(W)) bus ();

    demux4_stream #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit       m_full [4];
    bit [7:0] m_data [4];
    bit [7:0] m_cnt  [4];

    logic        obs_rdy;
    logic [3:0]  obs_valid;
    logic [31:0] obs_data;
    logic [31:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare outputs against the model, advance the model.
    task automatic step(input bit v, input bit [1:0] s, input bit [7:0] d,
                        input bit [3:0] r, input bit rs);
        logic [3:0]  e_valid;
        logic [31:0] e_data;
        logic [31:0] e_cnt;
        bit          e_rdy;
        bit          take;
        @(negedge clk);
        bus.in_valid_i  = v;
        bus.in_sel_i    = s;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
        rst             = rs;
        #1;
        e_rdy = !m_full[s] || r[s];
        for (int k = 0; k < 4; k++) begin
            e_valid[k]         = m_full[k];
            e_data[k*8 +: 8]   = m_data[k];
`ifdef DEMUX4_STREAM_CNT_EN
            e_cnt[k*8 +: 8]    = m_cnt[k];
`else
            e_cnt[k*8 +: 8]    = 8'h00;
`endif
        end
        obs_rdy   = bus.in_ready_o;
        obs_valid = bus.out_valid_o;
        obs_data  = bus.out_data_o;
        obs_cnt   = bus.cnt_o;
        chk("in_ready", {31'b0, obs_rdy}, {31'b0, e_rdy});
        chk("out_valid", {28'b0, obs_valid}, {28'b0, e_valid});
        chk("out_data", obs_data, e_data);
        chk("cnt", obs_cnt, e_cnt);
        if (!rs) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 0;
                m_data[k] = 8'h00;
                m_cnt[k]  = 8'h00;
            end
        end else begin
            take = v && e_rdy;
            for (int k = 0; k < 4; k++) begin
                if (take && s == k) begin
                    m_full[k] = 1;
                    m_data[k] = d;
                    m_cnt[k]  = m_cnt[k] + 8'd1;
                end else if (m_full[k] && r[k]) begin
                    m_full[k] = 0;
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        rst             = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_sel_i    = 2'd0;
        bus.in_data_i   = 8'h00;
        bus.out_ready_i = 4'h0;
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_data[k] = 8'h00;
            m_cnt[k]  = 8'h00;
        end
        repeat (2) @(posedge clk);

        // Reset then idle: ready for every select
        for (int i = 0; i < 4; i++) begin
            step(0, 2'(i), 8'h00, 4'h0, 1);
            chk("idle_rdy", {31'b0, obs_rdy}, 32'd1);
            chk("idle_valid", {28'b0, obs_valid}, 32'd0);
            chk("idle_data", obs_data, 32'd0);
            chk("idle_cnt", obs_cnt, 32'd0);
        end

        // Single route to channel 2 then blocked second beat
        step(1, 2'd2, 8'hA5, 4'h0, 1);
        step(1, 2'd2, 8'h5A, 4'h0, 1);
        chk("route_valid", {28'b0, obs_valid}, 32'h4);
        chk("route_data", {24'b0, obs_data[23:16]}, 32'hA5);
        chk("route_block", {31'b0, obs_rdy}, 32'd0);
        step(0, 2'd0, 8'h00, 4'h0, 1);
        chk("route_hold", {24'b0, obs_data[23:16]}, 32'hA5);
        step(0, 2'd0, 8'h00, 4'b0100, 1);

        // Pass-through refill on channel 1
        step(1, 2'd1, 8'h11, 4'h0, 1);
        step(1, 2'd1, 8'h22, 4'b0010, 1);
        chk("pt_rdy", {31'b0, obs_rdy}, 32'd1);
        chk("pt_old", {24'b0, obs_data[15:8]}, 32'h11);
        step(0, 2'd0, 8'h00, 4'h0, 1);
        chk("pt_valid", {31'b0, obs_valid[1]}, 32'd1);
        chk("pt_new", {24'b0, obs_data[15:8]}, 32'h22);
        step(0, 2'd0, 8'h00, 4'b0010, 1);

        // Independence: channel 0 stalled while channel 3 streams
        step(1, 2'd0, 8'hC0, 4'h0, 1);
        step(1, 2'd3, 8'h30, 4'b1000, 1);
        step(1, 2'd3, 8'h31, 4'b1000, 1);
        chk("ind_d30", {24'b0, obs_data[31:24]}, 32'h30);
        step(0, 2'd0, 8'h00, 4'b1000, 1);
        chk("ind_d31", {24'b0, obs_data[31:24]}, 32'h31);
        chk("ind_valid", {28'b0, obs_valid}, 32'h9);
        step(0, 2'd0, 8'h00, 4'h0, 1);
        chk("ind_ch0", {24'b0, obs_data[7:0]}, 32'hC0);
        chk("ind_valid2", {28'b0, obs_valid}, 32'h1);

        // Reset with all channels full and a handshake in flight
        for (int k = 1; k < 4; k++) step(1, 2'(k), 8'(8'h40 + k), 4'h0, 1);
        step(0, 2'd0, 8'h00, 4'h0, 1);
        chk("full_all", {28'b0, obs_valid}, 32'hF);
        step(1, 2'd2, 8'h77, 4'hF, 0);
        step(1, 2'd1, 8'h99, 4'h0, 1);
        chk("rst_valid", {28'b0, obs_valid}, 32'd0);
        chk("rst_data", obs_data, 32'd0);
        chk("rst_cnt", obs_cnt, 32'd0);
        step(0, 2'd0, 8'h00, 4'h0, 1);
        chk("post_valid", {28'b0, obs_valid}, 32'h2);
        chk("post_data", {24'b0, obs_data[15:8]}, 32'h99);
        step(0, 2'd0, 8'h00, 4'b0010, 1);

        // Counter wrap on channel 0
        for (int i = 0; i < 256; i++) step(1, 2'd0, 8'(i), 4'b0001, 1);
        step(0, 2'd0, 8'h00, 4'b0001, 1);
        chk("wrap_cnt0", {24'b0, obs_cnt[7:0]}, 32'd0);
        step(1, 2'd0, 8'hE1, 4'b0001, 1);
        step(1, 2'd0, 8'hE2, 4'b0001, 1);
        step(0, 2'd0, 8'h00, 4'b0001, 1);
`ifdef DEMUX4_STREAM_CNT_EN
        chk("wrap_cnt2", {24'b0, obs_cnt[7:0]}, 32'd2);
`else
        chk("wrap_cnt2", {24'b0, obs_cnt[7:0]}, 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 4'($urandom), bit'($urandom_range(0, 63) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Stream demultiplexer: the distribution counterpart to the 4-to-1 selector in the Lab2 datapath. Each input beat carries a 2-bit select, and the block routes that beat to one of four output channels. Each channel has its own one-entry registered buffer and its own valid/ready handshake. It sits between a single producer and four independent consumers.

## Interface
Parameters:
- WIDTH, 8, data width of every beat.

Ports (clock and reset first):
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- in_valid_i  in  1  producer has a beat.
- in_ready_o  out  1  block accepts the beat this cycle.
- in_data_i  in  WIDTH  beat payload.
- in_sel_i  in  2  destination channel 0..3.
- out_valid_o  out  4  bit k: channel k buffer holds a beat.
- out_ready_i  in  4  bit k: consumer k takes the beat.
- out_data_o  out  4*WIDTH  channel k payload at [k*WIDTH +: WIDTH].
- cnt_o  out  32  per-channel accepted-beat counters, channel k at [k*8 +: 8]. Present always; function depends on the configuration macro.

## Operation
- Per channel k, the state is full[k] and data[k].
- Input acceptance:
  - in_ready_o = ~full[in_sel_i] | out_ready_i[in_sel_i]. This is combinational, with no dependence on in_valid_i.
  - An input transfer occurs when in_valid_i & in_ready_o. It writes data[in_sel_i] <= in_data_i and sets full[in_sel_i] <= 1.
- Output drain: an output transfer on k occurs when out_valid_o[k] & out_ready_i[k]. It clears full[k], unless the same cycle's input transfer targets k; in that case full[k] stays 1 and data[k] takes the new beat (pass-through refill).
- Channels other than in_sel_i are independent. Any number of channels may drain in the same cycle.
- out_valid_o[k] = full[k]. out_data_o slice k = data[k]; it is held stable while out_valid_o[k]=1 and not drained.
- Data on a non-selected channel is never modified.
- in_sel_i and in_data_i are ignored when in_valid_i=0.
- Per-channel state: EMPTY -> FULL on input transfer. FULL -> EMPTY on drain without refill. FULL -> FULL on refill or on hold.
- Ordering: beats to the same channel leave in arrival order, because there is at most one beat outstanding per channel.

## Timing
- Latency: a beat accepted at edge N is visible on out_valid_o/out_data_o after edge N. That is 1 cycle, with no combinational path from in_data_i to out_data_o.
- Throughput: 1 beat/cycle per channel when the consumer keeps out_ready_i high.
- Combinational paths: from in_sel_i and out_ready_i to in_ready_o only.
- Reset (rst_i=0 at an edge) applies regardless of any handshake in flight; the in-flight beat is lost:
  - full = 0, out_valid_o = 0.
  - data = 0, out_data_o = 0.
  - cnt_o = 0.
- While rst_i=0, in_ready_o still evaluates combinationally, but no transfer is recorded.

## Configuration
- Macro: DEMUX4_STREAM_CNT_EN.
- Defined:
  - Channel k counter increments by 1 on each input transfer to k.
  - Counters are 8-bit and wrap 255 -> 0.
  - Counters are cleared only by reset.
- Undefined: cnt_o is tied to 0 and no counter flops are built.

## Structure
- Package demux4_pkg holds:
  - NUM_CH = 4
  - SEL_W = 2
  - CNT_W = 8
  - the slice-index helper for the flattened out_data_o.
- Sub-module demux4_slot (one-entry buffer: load, drain, refill; outputs full, data) is instantiated four times. The top holds the select decode, in_ready_o, and the counters.

## Test plan
- Reset then idle: after rst_i low for 2 cycles, out_valid_o=4'b0000, out_data_o=0, cnt_o=0, and in_ready_o=1 for all in_sel_i.
- Single route: sel=2, data=8'hA5, out_ready_i=0 -> next cycle out_valid_o=4'b0100, slice 2=8'hA5. A second beat to sel=2 then sees in_ready_o=0 and is not accepted; slice 2 stays 8'hA5.
- Back-pressure with pass-through: channel 1 full with 8'h11, out_ready_i[1]=1, input sel=1 data 8'h22 in the same cycle -> in_ready_o=1, out_valid_o[1] stays 1, slice 1=8'h22 next cycle.
- Independence: channel 0 full and stalled; beats to sel=3 (8'h30, 8'h31) with out_ready_i[3]=1 -> both delivered on consecutive cycles, and channel 0 holds its data unchanged.
- Reset mid-operation: all four channels full, rst_i=0 for one edge -> all outputs zero. Accepted beats after reset are delivered normally.
- Counter wrap (DEMUX4_STREAM_CNT_EN defined): 256 beats to sel=0 -> cnt_o[7:0]=0. Further beats count 1, 2... Without the macro, cnt_o stays 0 throughout.
